// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer:
//   - executor opcode constants, plus the sequencer-only NOP and HALT codes
//   - the sequencer state enum
//   - instruction field slices: [19:16] opcode, [15:8] R1, [7:0] R2/C
package seq_pkg;

  localparam int INSTR_W = 20;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_FLUSH,
    S_HALTED,
    S_FAULT
  } state_t;

  function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] w);
    return w[19:16];
  endfunction

  function automatic logic [7:0] instr_r1(input logic [INSTR_W-1:0] w);
    return w[15:8];
  endfunction

  function automatic logic [7:0] instr_r2(input logic [INSTR_W-1:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program memory: 2^A words of W bits, synchronous write, synchronous read.
// The array itself is never reset so a loaded program survives ResetN; only
// the read register (the sequencer's IR) is cleared.
// Ports:
//   Clock, ResetN       clock, async active-low reset (read register only)
//   we, waddr, wdata    write port
//   re, raddr           read enable / address, data lands in rdata next edge
//   rdata               registered read data
module prog_ram #(
  parameter int A = 4,
  parameter int W = 20
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2**A];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/op_sequencer.sv
// Instruction sequencer feeding the executor. Fetches 20-bit words from a
// small program RAM, presents each on OpCode until the executor returns
// Done, then forces a zero gap (FLUSH/FETCH/DECODE) so the executor's step
// timer returns to its default state before the next instruction.
// Ports:
//   Clock, ResetN          clock, async active-low reset
//   Start                  run from address 0 (ignored while Busy)
//   LoadEn/LoadAddr/Data   program write port (ignored while Busy)
//   Done                   executor completion
//   OpCode                 instruction to executor, 0 between instructions
//   Busy/Halted/Fault      state flags decoded from the state register
//   PC                     address of the current instruction
//   Retired                completed instructions, saturating at 255
module op_sequencer
  import seq_pkg::*;
#(
  parameter int A       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Start,
  input  logic               LoadEn,
  input  logic [A-1:0]       LoadAddr,
  input  logic [INSTR_W-1:0] LoadData,
  input  logic               Done,
  output logic [INSTR_W-1:0] OpCode,
  output logic               Busy,
  output logic               Halted,
  output logic               Fault,
  output logic [A-1:0]       PC,
  output logic [7:0]         Retired
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [A-1:0]       pc_d;
  logic [INSTR_W-1:0] opcode_d;
  logic [7:0]         retired_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [INSTR_W-1:0] ir;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign Busy   = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                  (state_q == S_WAIT)  || (state_q == S_FLUSH);
  assign Halted = (state_q == S_HALTED);
  assign Fault  = (state_q == S_FAULT);

  // IR is the RAM read register, loaded on the FETCH edge
  prog_ram #(.A(A), .W(INSTR_W)) u_ram (
    .Clock  (Clock),
    .ResetN (ResetN),
    .we     (LoadEn && !Busy),
    .waddr  (LoadAddr),
    .wdata  (LoadData),
    .re     (state_q == S_FETCH),
    .raddr  (PC),
    .rdata  (ir)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = PC;
    opcode_d  = OpCode;
    retired_d = Retired;
    wd_d      = wd_q;
    case (state_q)
      S_IDLE, S_HALTED, S_FAULT: begin
        if (Start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (instr_op(ir) == OP_NOP) begin
          pc_d    = PC + A'(1);
          state_d = S_FETCH;
        end else if (instr_op(ir) == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          opcode_d = ir;
          wd_d     = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done is checked first so it wins over a same-cycle timeout
        if (Done) begin
          opcode_d  = '0;
          retired_d = sat_inc8(Retired);
          state_d   = S_FLUSH;
        end else if (wd_q + WD_W'(1) == WD_LAST) begin
          opcode_d = '0;
          state_d  = S_FAULT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_FLUSH: begin
        pc_d    = PC + A'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      PC      <= '0;
      OpCode  <= '0;
      Retired <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      PC      <= pc_d;
      OpCode  <= opcode_d;
      Retired <= retired_d;
      wd_q    <= wd_d;
    end
  end

endmodule
